servo_button_conditioner: RTL and testbench

Front end for the servo PWM stage. It takes the two raw, active-low increment/decrement pushbuttons, synchronises and debounces them, and adds hold-to-repeat. It drives one-cycle `inc_pulse` / `dec_pulse` step requests on `clk`, so the PWM stage steps its duty register on pulses and needs no edge detection or slow clock.

---
 rtl/servo_button_conditioner.sv | 226 ++++++++++++++++++++++
 tb/tb_servo_button_conditioner.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/servo_button_conditioner.sv
// Servo pushbutton front end: two identical button channels (synchroniser,
// debouncer, hold-to-repeat FSM) plus the cross-channel conflict gating that
// produces mutually exclusive one-cycle inc/dec step pulses.

module servo_button_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic pb,
    output logic held,
    output logic rise,
    output logic fire
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ARMED_WAIT = 2'd1,
        ST_HOLD_WAIT  = 2'd2,
        ST_REPEAT     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             pressed_s;
    logic             held_r;
    logic             held_d_r;
    logic [CNT_W-1:0] deb_cnt_r;
    state_t           state_r;
    state_t           state_n_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_n_s;
    logic             fire_s;

    // Two-stage synchroniser; resets to the released (high) level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= pb;
            sync2_r <= sync1_r;
        end
    end

    assign pressed_s = ~sync2_r;

    // Debouncer: held flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_r    <= 1'b0;
            deb_cnt_r <= CNT_ZERO;
        end else if (pressed_s == held_r) begin
            deb_cnt_r <= CNT_ZERO;
        end else if (deb_cnt_r == DEB_LAST) begin
            held_r    <= ~held_r;
            deb_cnt_r <= CNT_ZERO;
        end else begin
            deb_cnt_r <= deb_cnt_r + CNT_ONE;
        end
    end

    // Delayed copy of held for press (rising edge) detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_d_r <= 1'b0;
        end else begin
            held_d_r <= held_r;
        end
    end

    // FSM state and hold/repeat counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    // Next-state logic: enable loss locks out until release, release returns to idle.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        fire_s    = 1'b0;
        if (!enable) begin
            state_n_s = ST_ARMED_WAIT;
            cnt_n_s   = CNT_ZERO;
        end else if (!held_r) begin
            state_n_s = ST_IDLE;
            cnt_n_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_n_s = CNT_ZERO;
                    if (rise) begin
                        fire_s    = 1'b1;
                        state_n_s = ST_HOLD_WAIT;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_ARMED_WAIT: begin
                    state_n_s = ST_ARMED_WAIT;
                    cnt_n_s   = CNT_ZERO;
                end
                ST_HOLD_WAIT: begin
                    if (cnt_r == HOLD_LAST) begin
                        fire_s    = 1'b1;
                        cnt_n_s   = CNT_ZERO;
                        state_n_s = ST_REPEAT;
                    end else begin
                        cnt_n_s = cnt_r + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (cnt_r == REP_LAST) begin
                        fire_s  = 1'b1;
                        cnt_n_s = CNT_ZERO;
                    end else begin
                        cnt_n_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_n_s = ST_IDLE;
                    cnt_n_s   = CNT_ZERO;
                end
            endcase
        end
    end

    assign held = held_r;
    assign rise = held_r & ~held_d_r;
    assign fire = fire_s;

endmodule

module servo_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic pb_inc,
    input  logic pb_dec,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_held,
    output logic dec_held
);

    logic inc_rise_s;
    logic dec_rise_s;
    logic inc_fire_s;
    logic dec_fire_s;
    logic both_held_s;
    logic inc_go_s;
    logic dec_go_s;
    logic inc_pulse_r;
    logic dec_pulse_r;

    servo_button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .CNT_W           (CNT_W)
    ) u_inc (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .pb     (pb_inc),
        .held   (inc_held),
        .rise   (inc_rise_s),
        .fire   (inc_fire_s)
    );

    servo_button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .CNT_W           (CNT_W)
    ) u_dec (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .pb     (pb_dec),
        .held   (dec_held),
        .rise   (dec_rise_s),
        .fire   (dec_fire_s)
    );

    // Both buttons down, or the other button just pressed, means the user intent is ambiguous.
    assign both_held_s = inc_held & dec_held;
    assign inc_go_s    = inc_fire_s & enable & ~both_held_s & ~dec_rise_s;
    assign dec_go_s    = dec_fire_s & enable & ~both_held_s & ~inc_rise_s & ~inc_go_s;

    // Output pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inc_pulse_r <= 1'b0;
            dec_pulse_r <= 1'b0;
        end else begin
            inc_pulse_r <= inc_go_s;
            dec_pulse_r <= dec_go_s;
        end
    end

    assign inc_pulse = inc_pulse_r;
    assign dec_pulse = dec_pulse_r;

endmodule

// File: tb/tb_servo_button_conditioner.sv
// Bench for servo_button_conditioner: directed scenarios plus random button
// activity, compared every cycle against an event-scheduling reference model.

module tb_servo_button_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b1;
    logic pb_inc = 1'b1;
    logic pb_dec = 1'b1;
    logic inc_pulse;
    logic dec_pulse;
    logic inc_held;
    logic dec_held;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_inc  = 0;
    int cnt_dec  = 0;
    int t_now    = 0;

    // reference model state: index 0 = inc, 1 = dec
    bit m_held[2];
    bit m_prev[2];
    bit m_dly[2][2];
    int m_run[2];
    bit m_blocked[2];
    bit m_active[2];
    int m_next[2];
    bit m_pulse[2];

    servo_button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP),
        .CNT_W           (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .pb_inc    (pb_inc),
        .pb_dec    (pb_dec),
        .inc_pulse (inc_pulse),
        .dec_pulse (dec_pulse),
        .inc_held  (inc_held),
        .dec_held  (dec_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_held[c] = 1'b0; m_prev[c] = 1'b0;
            m_dly[c][0] = 1'b0; m_dly[c][1] = 1'b0;
            m_run[c] = 0; m_blocked[c] = 1'b0; m_active[c] = 1'b0;
            m_next[c] = 0; m_pulse[c] = 1'b0;
        end
    endtask

    // One clock edge of the reference model, from the rules:
    // pulses are scheduled as absolute times (press, +HOLD, then +REP each).
    task automatic model_step(input bit en, input bit pi, input bit pd);
        bit rise[2];
        bit fire[2];
        bit both;
        bit seen;
        bit raw_pressed[2];
        raw_pressed[0] = !pi;
        raw_pressed[1] = !pd;
        for (int c = 0; c < 2; c++) begin
            rise[c] = m_held[c] && !m_prev[c];
            fire[c] = 1'b0;
            if (!en) begin
                m_blocked[c] = 1'b1; m_active[c] = 1'b0;
            end else if (!m_held[c]) begin
                m_blocked[c] = 1'b0; m_active[c] = 1'b0;
            end else if (m_blocked[c]) begin
                fire[c] = 1'b0;
            end else if (!m_active[c]) begin
                if (rise[c]) begin
                    fire[c] = 1'b1; m_active[c] = 1'b1; m_next[c] = t_now + HOLD;
                end
            end else if (t_now == m_next[c]) begin
                fire[c] = 1'b1; m_next[c] = t_now + REP;
            end
        end
        both = m_held[0] && m_held[1];
        m_pulse[0] = fire[0] && !both && !rise[1];
        m_pulse[1] = fire[1] && !both && !rise[0];
        for (int c = 0; c < 2; c++) begin
            seen = m_dly[c][1];
            m_dly[c][1] = m_dly[c][0];
            m_dly[c][0] = raw_pressed[c];
            m_prev[c] = m_held[c];
            if (seen != m_held[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    m_held[c] = !m_held[c]; m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        t_now++;
    endtask

    task automatic step(input logic r, input logic en, input logic pi, input logic pd);
        rst = r; enable = en; pb_inc = pi; pb_dec = pd;
        if (!r) begin
            model_reset();
            #1;
            check("rst_async_inc_pulse", inc_pulse, 0);
            check("rst_async_dec_pulse", dec_pulse, 0);
            check("rst_async_inc_held", inc_held, 0);
            check("rst_async_dec_held", dec_held, 0);
        end
        @(posedge clk);
        if (r) model_step(en, pi, pd);
        #1;
        check("inc_pulse", inc_pulse, m_pulse[0]);
        check("dec_pulse", dec_pulse, m_pulse[1]);
        check("inc_held", inc_held, m_held[0]);
        check("dec_held", dec_held, m_held[1]);
        check("pulse_exclusive", inc_pulse & dec_pulse, 0);
        if (inc_pulse) cnt_inc++;
        if (dec_pulse) cnt_dec++;
    endtask

    task automatic run(input int n, input logic r, input logic en, input logic pi, input logic pd);
        repeat (n) step(r, en, pi, pd);
    endtask

    task automatic clear_counts();
        cnt_inc = 0;
        cnt_dec = 0;
    endtask

    initial begin
        int seg_len;
        bit pi;
        bit pd;
        bit en;
        model_reset();

        // reset
        run(2, 1'b0, 1'b1, 1'b1, 1'b1);
        run(3, 1'b1, 1'b1, 1'b1, 1'b1);

        // single short press
        clear_counts();
        run(10, 1'b1, 1'b1, 1'b0, 1'b1);
        run(12, 1'b1, 1'b1, 1'b1, 1'b1);
        check("short_press_inc_count", cnt_inc, 1);
        check("short_press_dec_count", cnt_dec, 0);

        // long hold with auto-repeat: pulses at 6, 26, 34, 42, 50, 58
        clear_counts();
        run(60, 1'b1, 1'b1, 1'b1, 1'b0);
        run(12, 1'b1, 1'b1, 1'b1, 1'b1);
        check("repeat_dec_count", cnt_dec, 6);
        check("repeat_inc_count", cnt_inc, 0);

        // contact bounce then settle
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            run(2, 1'b1, 1'b1, 1'b0, 1'b1);
            run(2, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        check("bounce_count", cnt_inc, 0);
        run(10, 1'b1, 1'b1, 1'b0, 1'b1);
        run(12, 1'b1, 1'b1, 1'b1, 1'b1);
        check("settle_count", cnt_inc, 1);

        // both pressed together, dec released first
        clear_counts();
        run(40, 1'b1, 1'b1, 1'b0, 1'b0);
        run(2, 1'b1, 1'b1, 1'b0, 1'b1);
        run(12, 1'b1, 1'b1, 1'b1, 1'b1);
        check("both_inc_count", cnt_inc, 0);
        check("both_dec_count", cnt_dec, 0);

        // press while disabled, enable rises during the hold
        clear_counts();
        run(10, 1'b1, 1'b0, 1'b0, 1'b1);
        run(10, 1'b1, 1'b1, 1'b0, 1'b1);
        run(12, 1'b1, 1'b1, 1'b1, 1'b1);
        check("enable_rise_count", cnt_inc, 0);
        run(10, 1'b1, 1'b1, 1'b0, 1'b1);
        run(12, 1'b1, 1'b1, 1'b1, 1'b1);
        check("enable_repress_count", cnt_inc, 1);

        // reset during HOLD_WAIT with the button still down
        run(10, 1'b1, 1'b1, 1'b0, 1'b1);
        clear_counts();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        run(15, 1'b1, 1'b1, 1'b0, 1'b1);
        run(12, 1'b1, 1'b1, 1'b1, 1'b1);
        check("post_reset_count", cnt_inc, 1);

        // random button activity
        for (int s = 0; s < 120; s++) begin
            pi = ($urandom_range(0, 2) != 0);
            pd = ($urandom_range(0, 2) != 0);
            en = ($urandom_range(0, 7) != 0);
            seg_len = $urandom_range(1, 30);
            if ($urandom_range(0, 39) == 0) step(1'b0, en, pi, pd);
            run(seg_len, 1'b1, en, pi, pd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
